// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pattern encoding and colour-bar table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    // 640x480 @ 60 Hz timing
    localparam int TOTAL_COLS    = 800;
    localparam int TOTAL_ROWS    = 525;
    localparam int ACTIVE_COLS   = 640;
    localparam int ACTIVE_ROWS   = 480;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_PULSE  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_PULSE  = 2;
    localparam int V_BACK_PORCH  = 33;

    localparam int COLOR_BITS = 3;
    localparam int BOX_SIZE   = 64;
    localparam int BAR_WIDTH  = ACTIVE_COLS / 8;

    // Largest legal top-left corner of the moving box
    localparam logic [9:0] BOX_X_MAX = 10'(ACTIVE_COLS - BOX_SIZE);
    localparam logic [9:0] BOX_Y_MAX = 10'(ACTIVE_ROWS - BOX_SIZE);

    typedef enum logic [2:0] {
        PAT_BLACK   = 3'd0,
        PAT_RED     = 3'd1,
        PAT_GREEN   = 3'd2,
        PAT_BLUE    = 3'd3,
        PAT_CHECKER = 3'd4,
        PAT_BARS    = 3'd5,
        PAT_BORDER  = 3'd6,
        PAT_BOX     = 3'd7
    } pattern_e;

    // One bit per channel; a set bit means that channel is driven full-scale
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_mask_t;

    // Colour bars, left to right
    function automatic rgb_mask_t bar_color(input logic [2:0] idx);
        rgb_mask_t c;
        case (idx)
            3'd0:    c = '{r: 1'b1, g: 1'b1, b: 1'b1}; // white
            3'd1:    c = '{r: 1'b1, g: 1'b1, b: 1'b0}; // yellow
            3'd2:    c = '{r: 1'b0, g: 1'b1, b: 1'b1}; // cyan
            3'd3:    c = '{r: 1'b0, g: 1'b1, b: 1'b0}; // green
            3'd4:    c = '{r: 1'b1, g: 1'b0, b: 1'b1}; // magenta
            3'd5:    c = '{r: 1'b1, g: 1'b0, b: 1'b0}; // red
            3'd6:    c = '{r: 1'b0, g: 1'b0, b: 1'b1}; // blue
            default: c = '{r: 1'b0, g: 1'b0, b: 1'b0}; // black
        endcase
        return c;
    endfunction

    // Bar number for an active column; meaningless (but harmless) in blanking
    function automatic logic [2:0] bar_index(input logic [9:0] col);
        return 3'(col / 10'(BAR_WIDTH));
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Bundle between the sync generator and the pattern generator.
// Latency: n/a (wires only).
// Backpressure: none; pixel stream is free-running at the pixel clock.
// Ports: i_* come from the sync generator side (master), o_* go to the DAC side.
interface vga_pattern_gen_if;
    import vga_pkg::*;

    logic                  i_hsync;
    logic                  i_vsync;
    logic [9:0]            i_row;
    logic [9:0]            i_col;
    logic [2:0]            i_pattern_sel;

    logic                  o_hsync;
    logic                  o_vsync;
    logic [COLOR_BITS-1:0] o_red;
    logic [COLOR_BITS-1:0] o_grn;
    logic [COLOR_BITS-1:0] o_blu;
    logic                  o_active;
    logic                  o_frame_start;

    modport master (
        output i_hsync, i_vsync, i_row, i_col, i_pattern_sel,
        input  o_hsync, o_vsync, o_red, o_grn, o_blu, o_active, o_frame_start
    );

    modport slave (
        input  i_hsync, i_vsync, i_row, i_col, i_pattern_sel,
        output o_hsync, o_vsync, o_red, o_grn, o_blu, o_active, o_frame_start
    );

endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position: steps (+-2, +-1) once per frame, clamping and reversing at the edges.
// Latency: new position visible the cycle after frame_tick.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), frame_tick in; box_x, box_y (top-left corner) out.
module vga_box_mover
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);

    logic [9:0] box_x_q, box_x_d;
    logic [9:0] box_y_q, box_y_d;
    logic       dir_x_q, dir_x_d;   // 1 = moving right
    logic       dir_y_q, dir_y_d;   // 1 = moving down

    // 11-bit candidates so a step past the limit cannot wrap
    logic [10:0] next_x;
    logic [10:0] next_y;

    always_comb begin
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        next_x  = {1'b0, box_x_q} + 11'd2;
        next_y  = {1'b0, box_y_q} + 11'd1;

        if (frame_tick) begin
            // Horizontal axis
            if (dir_x_q) begin
                if (next_x > {1'b0, BOX_X_MAX}) begin
                    box_x_d = BOX_X_MAX;
                    dir_x_d = 1'b0;
                end else begin
                    box_x_d = next_x[9:0];
                end
            end else begin
                if (box_x_q < 10'd2) begin
                    box_x_d = 10'd0;
                    dir_x_d = 1'b1;
                end else begin
                    box_x_d = box_x_q - 10'd2;
                end
            end

            // Vertical axis, independent of the horizontal one
            if (dir_y_q) begin
                if (next_y > {1'b0, BOX_Y_MAX}) begin
                    box_y_d = BOX_Y_MAX;
                    dir_y_d = 1'b0;
                end else begin
                    box_y_d = next_y[9:0];
                end
            end else begin
                if (box_y_q < 10'd1) begin
                    box_y_d = 10'd0;
                    dir_y_d = 1'b1;
                end else begin
                    box_y_d = box_y_q - 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x_q <= '0;
            box_y_q <= '0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign box_x = box_x_q;
    assign box_y = box_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// RGB test-pattern generator for the 640x480 active region, syncs re-timed to match colour.
// Latency: fixed 2 cycles from bus inputs to every output.
// Backpressure: none; consumes and produces one pixel per clock.
// Ports: clk, rst (sync, active-high), bus (vga_pattern_gen_if.slave).
// Build option: define VGA_PATTERN_MOVING_BOX_EN to build pattern 7 (moving box); otherwise it is black.
module vga_pattern_gen
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    vga_pattern_gen_if.slave  bus
);

    // Pattern latched at the frame boundary; applies from the next (0,0)
    pattern_e   pattern_q, pattern_d;
    logic       frame_tick;

    // Stage 1: raw syncs plus per-pixel decode
    logic       hsync_s1_q, hsync_s1_d;
    logic       vsync_s1_q, vsync_s1_d;
    logic       active_s1_q, active_s1_d;
    logic       frame_start_s1_q, frame_start_s1_d;
    pattern_e   pattern_s1_q, pattern_s1_d;
    logic       checker_s1_q, checker_s1_d;
    logic [2:0] bar_s1_q, bar_s1_d;
    logic       border_s1_q, border_s1_d;

    // Stage 2: output registers
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  active_q, active_d;
    logic                  frame_start_q, frame_start_d;
    logic [COLOR_BITS-1:0] red_q, red_d;
    logic [COLOR_BITS-1:0] grn_q, grn_d;
    logic [COLOR_BITS-1:0] blu_q, blu_d;
    rgb_mask_t             mask;

    assign frame_tick = (bus.i_col == 10'(TOTAL_COLS - 1)) && (bus.i_row == 10'(TOTAL_ROWS - 1));

`ifdef VGA_PATTERN_MOVING_BOX_EN
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       in_box_s1_q, in_box_s1_d;

    // Box only moves on the boundary pixel, so it is stable across the whole active region
    vga_box_mover u_box_mover (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    always_comb begin
        in_box_s1_d = ({1'b0, bus.i_col} >= {1'b0, box_x}) &&
                      ({1'b0, bus.i_col} <  ({1'b0, box_x} + 11'(BOX_SIZE))) &&
                      ({1'b0, bus.i_row} >= {1'b0, box_y}) &&
                      ({1'b0, bus.i_row} <  ({1'b0, box_y} + 11'(BOX_SIZE)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_box_s1_q <= 1'b0;
        end else begin
            in_box_s1_q <= in_box_s1_d;
        end
    end
`endif

    // Stage 1 next-state
    always_comb begin
        pattern_d = pattern_q;
        if (frame_tick) begin
            pattern_d = pattern_e'(bus.i_pattern_sel);
        end

        hsync_s1_d       = bus.i_hsync;
        vsync_s1_d       = bus.i_vsync;
        active_s1_d      = (bus.i_col < 10'(ACTIVE_COLS)) && (bus.i_row < 10'(ACTIVE_ROWS));
        frame_start_s1_d = (bus.i_col == 10'd0) && (bus.i_row == 10'd0);
        pattern_s1_d     = pattern_q;
        checker_s1_d     = bus.i_col[5] ^ bus.i_row[5];
        bar_s1_d         = bar_index(bus.i_col);
        border_s1_d      = (bus.i_col == 10'd0) || (bus.i_col == 10'(ACTIVE_COLS - 1)) ||
                           (bus.i_row == 10'd0) || (bus.i_row == 10'(ACTIVE_ROWS - 1));
    end

    // Stage 2 next-state: colour from the decoded pattern, blanked outside the active region
    always_comb begin
        mask = '{r: 1'b0, g: 1'b0, b: 1'b0};
        case (pattern_s1_q)
            PAT_RED:     mask = '{r: 1'b1, g: 1'b0, b: 1'b0};
            PAT_GREEN:   mask = '{r: 1'b0, g: 1'b1, b: 1'b0};
            PAT_BLUE:    mask = '{r: 1'b0, g: 1'b0, b: 1'b1};
            PAT_CHECKER: mask = {3{checker_s1_q}};
            PAT_BARS:    mask = bar_color(bar_s1_q);
            PAT_BORDER:  mask = {3{border_s1_q}};
`ifdef VGA_PATTERN_MOVING_BOX_EN
            PAT_BOX:     mask = in_box_s1_q ? 3'b111 : 3'b001;
`endif
            default:     mask = '{r: 1'b0, g: 1'b0, b: 1'b0};
        endcase
        if (!active_s1_q) begin
            mask = '{r: 1'b0, g: 1'b0, b: 1'b0};
        end

        hsync_d       = hsync_s1_q;
        vsync_d       = vsync_s1_q;
        active_d      = active_s1_q;
        frame_start_d = frame_start_s1_q;
        red_d         = {COLOR_BITS{mask.r}};
        grn_d         = {COLOR_BITS{mask.g}};
        blu_d         = {COLOR_BITS{mask.b}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q        <= PAT_BLACK;
            hsync_s1_q       <= 1'b1;
            vsync_s1_q       <= 1'b1;
            active_s1_q      <= 1'b0;
            frame_start_s1_q <= 1'b0;
            pattern_s1_q     <= PAT_BLACK;
            checker_s1_q     <= 1'b0;
            bar_s1_q         <= '0;
            border_s1_q      <= 1'b0;
            hsync_q          <= 1'b1;
            vsync_q          <= 1'b1;
            active_q         <= 1'b0;
            frame_start_q    <= 1'b0;
            red_q            <= '0;
            grn_q            <= '0;
            blu_q            <= '0;
        end else begin
            pattern_q        <= pattern_d;
            hsync_s1_q       <= hsync_s1_d;
            vsync_s1_q       <= vsync_s1_d;
            active_s1_q      <= active_s1_d;
            frame_start_s1_q <= frame_start_s1_d;
            pattern_s1_q     <= pattern_s1_d;
            checker_s1_q     <= checker_s1_d;
            bar_s1_q         <= bar_s1_d;
            border_s1_q      <= border_s1_d;
            hsync_q          <= hsync_d;
            vsync_q          <= vsync_d;
            active_q         <= active_d;
            frame_start_q    <= frame_start_d;
            red_q            <= red_d;
            grn_q            <= grn_d;
            blu_q            <= blu_d;
        end
    end

    assign bus.o_hsync       = hsync_q;
    assign bus.o_vsync       = vsync_q;
    assign bus.o_active      = active_q;
    assign bus.o_frame_start = frame_start_q;
    assign bus.o_red         = red_q;
    assign bus.o_grn         = grn_q;
    assign bus.o_blu         = blu_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen: constant vectors, corner sequences and randomized pixels vs a reference model.
// Latency: model expects every output 2 clocks after its input pixel.
// Backpressure: none.
module tb_vga_pattern_gen;
    import vga_pkg::*;

`ifdef VGA_PATTERN_MOVING_BOX_EN
    localparam bit BOX_EN = 1'b1;
`else
    localparam bit BOX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_pattern_gen_if vif ();

    vga_pattern_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [2:0] rgb;   // {r,g,b}, each bit = channel full-scale
    } pix_t;

    typedef struct {
        int         pat;
        int         col;
        int         row;
        logic [2:0] rgb;
        logic       act;
    } vec_t;

    localparam pix_t RST_REC = pix_t'{1'b1, 1'b1, 1'b0, 1'b0, 3'b000};

    int   checks;
    int   failures;

    // Reference model state (plain integers)
    int   m_pat;
    int   m_bx, m_by, m_dx, m_dy;
    pix_t m_stage;   // pixel sampled at the last edge, appears at the next

    function automatic logic [12:0] expand(input pix_t p);
        return {p.hs, p.vs, p.act, p.fs, {3{p.rgb[2]}}, {3{p.rgb[1]}}, {3{p.rgb[0]}}};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {vif.o_hsync, vif.o_vsync, vif.o_active, vif.o_frame_start,
                vif.o_red, vif.o_grn, vif.o_blu};
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic pix_t model_pixel(input int col, input int row, input logic hs, input logic vs);
        pix_t       p;
        logic [2:0] bars [8];
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        p.hs  = hs;
        p.vs  = vs;
        p.act = (col < 640) && (row < 480);
        p.fs  = (col == 0) && (row == 0);
        case (m_pat)
            1: p.rgb = 3'b100;
            2: p.rgb = 3'b010;
            3: p.rgb = 3'b001;
            4: p.rgb = (((col / 32) % 2) != ((row / 32) % 2)) ? 3'b111 : 3'b000;
            5: p.rgb = bars[(col / 80) % 8];
            6: p.rgb = (col == 0 || col == 639 || row == 0 || row == 479) ? 3'b111 : 3'b000;
            7: begin
                if (!BOX_EN) p.rgb = 3'b000;
                else if (col >= m_bx && col < m_bx + 64 && row >= m_by && row < m_by + 64) p.rgb = 3'b111;
                else p.rgb = 3'b001;
            end
            default: p.rgb = 3'b000;
        endcase
        if (!p.act) p.rgb = 3'b000;
        return p;
    endfunction

    task automatic model_move_box();
        int nx, ny;
        nx = m_bx + m_dx;
        ny = m_by + m_dy;
        if (nx < 0)        begin m_bx = 0;   m_dx = -m_dx; end
        else if (nx > 576) begin m_bx = 576; m_dx = -m_dx; end
        else                     m_bx = nx;
        if (ny < 0)        begin m_by = 0;   m_dy = -m_dy; end
        else if (ny > 416) begin m_by = 416; m_dy = -m_dy; end
        else                     m_by = ny;
    endtask

    // One pixel clock: drive, advance the model at the edge, compare #1 later
    task automatic step(input int col, input int row, input logic hs, input logic vs,
                        input int sel, input logic r, input string tag);
        pix_t exp_out;
        vif.i_col         = 10'(col);
        vif.i_row         = 10'(row);
        vif.i_hsync       = hs;
        vif.i_vsync       = vs;
        vif.i_pattern_sel = 3'(sel);
        rst               = r;
        @(posedge clk);
        if (r) begin
            exp_out = RST_REC;
            m_stage = RST_REC;
            m_pat = 0; m_bx = 0; m_by = 0; m_dx = 2; m_dy = 1;
        end else begin
            exp_out = m_stage;
            m_stage = model_pixel(col, row, hs, vs);
            if (col == 799 && row == 524) begin
                m_pat = sel;
                model_move_box();
            end
        end
        #1;
        chk(tag, dut_vec(), expand(exp_out));
    endtask

    task automatic idle(input string tag);
        step(700, 500, 1'b1, 1'b1, 0, 1'b0, tag);
    endtask

    vec_t vt [20];

    initial begin
        int bx, by;
        logic [12:0] e;
        checks   = 0;
        failures = 0;
        m_pat = 0; m_bx = 0; m_by = 0; m_dx = 2; m_dy = 1;
        m_stage = RST_REC;

        // Reset and reset values
        step(0, 0, 1'b0, 1'b0, 0, 1'b1, "reset");
        step(0, 0, 1'b0, 1'b0, 0, 1'b1, "reset");
        step(0, 0, 1'b0, 1'b0, 0, 1'b1, "reset");
        chk("reset_state", dut_vec(), 13'b1100_000000000);

        // Frame 0 after reset is black even though sel=1 is requested
        step(100, 100, 1'b1, 1'b1, 1, 1'b0, "frame0");
        idle("frame0");
        chk("frame0_black", dut_vec(), 13'b1110_000000000);

        // Constant vectors: each sets its pattern at a boundary then shows one pixel
        vt[0]  = '{1, 100, 100, 3'b100, 1'b1};
        vt[1]  = '{1, 640, 100, 3'b000, 1'b0};
        vt[2]  = '{1, 100, 480, 3'b000, 1'b0};
        vt[3]  = '{1, 1023, 10, 3'b000, 1'b0};
        vt[4]  = '{2, 639, 479, 3'b010, 1'b1};
        vt[5]  = '{3, 0,   0,   3'b001, 1'b1};
        vt[6]  = '{4, 32,  0,   3'b111, 1'b1};
        vt[7]  = '{4, 0,   0,   3'b000, 1'b1};
        vt[8]  = '{4, 32,  32,  3'b000, 1'b1};
        vt[9]  = '{4, 0,   32,  3'b111, 1'b1};
        vt[10] = '{5, 80,  10,  3'b110, 1'b1};
        vt[11] = '{5, 0,   0,   3'b111, 1'b1};
        vt[12] = '{5, 160, 0,   3'b011, 1'b1};
        vt[13] = '{5, 320, 0,   3'b101, 1'b1};
        vt[14] = '{5, 639, 5,   3'b000, 1'b1};
        vt[15] = '{6, 0,   200, 3'b111, 1'b1};
        vt[16] = '{6, 639, 5,   3'b111, 1'b1};
        vt[17] = '{6, 5,   479, 3'b111, 1'b1};
        vt[18] = '{6, 5,   5,   3'b000, 1'b1};
        vt[19] = '{0, 100, 100, 3'b000, 1'b1};
        for (int i = 0; i < 20; i++) begin
            step(799, 524, 1'b1, 1'b1, vt[i].pat, 1'b0, "vec_bnd");
            step(vt[i].col, vt[i].row, 1'b1, 1'b1, (vt[i].pat + 3) % 8, 1'b0, "vec_pix");
            idle("vec_idle");
            e = expand(pix_t'{1'b1, 1'b1, vt[i].act,
                              (vt[i].col == 0 && vt[i].row == 0), vt[i].rgb});
            chk($sformatf("vec%0d", i), dut_vec(), e);
        end

        // Pattern request 4 -> 5 mid-frame: change waits for the boundary
        step(799, 524, 1'b1, 1'b1, 4, 1'b0, "mid_sel");
        step(32, 0, 1'b1, 1'b1, 5, 1'b0, "mid_sel");
        idle("mid_sel");
        chk("mid_sel_32_0_white", dut_vec(), 13'b1110_111111111);
        step(0, 0, 1'b1, 1'b1, 5, 1'b0, "mid_sel");
        idle("mid_sel");
        chk("mid_sel_0_0_black", dut_vec(), 13'b1111_000000000);
        step(799, 524, 1'b1, 1'b1, 5, 1'b0, "mid_sel");
        step(80, 10, 1'b1, 1'b1, 2, 1'b0, "mid_sel");
        idle("mid_sel");
        chk("next_frame_yellow", dut_vec(), 13'b1110_111111000);

        // Moving box over enough frames to bounce on both axes
        for (int f = 0; f < 450; f++) begin
            step(799, 524, 1'b1, 1'b1, 7, 1'b0, "box_bnd");
            bx = m_bx;
            by = m_by;
            step(bx, by, 1'b1, 1'b1, 0, 1'b0, "box_pix");
            step(bx + 64, by, 1'b1, 1'b1, 0, 1'b0, "box_pix");
            chk("box_corner", dut_vec(),
                BOX_EN ? 13'b1110_111111111 : 13'b1110_000000000);
            step(bx + 63, by + 63, 1'b1, 1'b1, 0, 1'b0, "box_pix");
            if (bx + 64 < 640)
                chk("box_right", dut_vec(), BOX_EN ? 13'b1110_000000111 : 13'b1110_000000000);
            else
                chk("box_right_blank", dut_vec(), 13'b1100_000000000);
            idle("box_idle");
        end

        // Reset mid-frame at (300,200): pattern reverts to black
        step(799, 524, 1'b1, 1'b1, 3, 1'b0, "mid_rst");
        step(299, 200, 1'b0, 1'b1, 0, 1'b0, "mid_rst");
        step(300, 200, 1'b0, 1'b1, 0, 1'b1, "mid_rst");
        chk("mid_rst_outputs", dut_vec(), 13'b1100_000000000);
        step(301, 200, 1'b1, 1'b0, 0, 1'b0, "mid_rst");
        chk("mid_rst_flushed", dut_vec(), 13'b1100_000000000);
        step(302, 200, 1'b1, 1'b1, 0, 1'b0, "mid_rst");
        chk("after_rst_black", dut_vec(), 13'b1010_000000000);

        // Randomized pixels, syncs and pattern requests against the model
        for (int n = 0; n < 6000; n++) begin
            int k;
            k = $urandom_range(0, 15);
            if (k == 0)
                step(799, 524, 1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'b0, "rand");
            else if (k == 1)
                step(0, 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'b0, "rand");
            else
                step($urandom_range(0, 1023), $urandom_range(0, 599), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 7), (n % 997 == 500), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
